sram_arb: RTL and testbench

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb.sv | 132 +++++++++++++
 tb/tb_sram_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb.sv
// Three-port SRAM arbiter: video has fixed priority, CPU/DMA share round-robin.
// Each access is ACCESS_CYCLES strobe cycles, then a DONE/ack cycle, then at least one IDLE cycle.
module sram_arb #(
  parameter int ACCESS_CYCLES = 2,
  parameter int AW            = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vid_req,
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic [AW-1:0] vid_addr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] dma_addr,
  input  logic          cpu_we,
  input  logic          dma_we,
  input  logic [7:0]    cpu_wdata,
  input  logic [7:0]    dma_wdata,
  output logic          vid_ack,
  output logic          cpu_ack,
  output logic          dma_ack,
  output logic [7:0]    rdata,
  output logic          cpu_hold,
  output logic [AW-1:0] ext_ad,
  output logic [7:0]    ext_dq_o,
  output logic          ext_dq_oe,
  input  logic [7:0]    ext_dq_i,
  output logic          ext_cs,
  output logic          ext_oe_n,
  output logic          ext_we_n
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [1:0] P_VID = 2'd0;
  localparam logic [1:0] P_CPU = 2'd1;
  localparam logic [1:0] P_DMA = 2'd2;

  logic [1:0]    state;
  logic [1:0]    gnt;
  logic          rr_cpu;
  logic [2:0]    cnt;
  logic          we_q;
  logic [7:0]    wdata_q;
  logic [AW-1:0] addr_q;

  logic          any_req;
  logic [1:0]    nxt_gnt;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [7:0]    sel_wdata;

  assign any_req = vid_req | cpu_req | dma_req;

  // Video always wins; rr_cpu breaks CPU/DMA ties in favour of the port not served last.
  always_comb begin
    nxt_gnt   = P_VID;
    sel_addr  = vid_addr;
    sel_we    = 1'b0;
    sel_wdata = 8'h00;
    if (vid_req) begin
      nxt_gnt = P_VID;
    end else if (cpu_req && (rr_cpu || !dma_req)) begin
      nxt_gnt   = P_CPU;
      sel_addr  = cpu_addr;
      sel_we    = cpu_we;
      sel_wdata = cpu_wdata;
    end else if (dma_req) begin
      nxt_gnt   = P_DMA;
      sel_addr  = dma_addr;
      sel_we    = dma_we;
      sel_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= P_VID;
      rr_cpu  <= 1'b1;
      cnt     <= 3'd0;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      addr_q  <= '0;
      rdata   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= nxt_gnt;
            addr_q  <= sel_addr;
            we_q    <= sel_we;
            wdata_q <= sel_wdata;
            cnt     <= 3'(ACCESS_CYCLES - 1);
            state   <= ACCESS;
            if (nxt_gnt == P_CPU)
              rr_cpu <= 1'b0;
            else if (nxt_gnt == P_DMA)
              rr_cpu <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            state <= DONE;
            if (!we_q)
              rdata <= ext_dq_i;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset clears them asynchronously.
  assign ext_ad    = addr_q;
  assign ext_dq_o  = wdata_q;
  assign ext_cs    = (state == ACCESS) || (state == DONE);
  assign ext_oe_n  = !((state == ACCESS) && !we_q);
  assign ext_we_n  = !((state == ACCESS) && we_q);
  assign ext_dq_oe = ext_cs && we_q;

  assign vid_ack  = (state == DONE) && (gnt == P_VID);
  assign cpu_ack  = (state == DONE) && (gnt == P_CPU);
  assign dma_ack  = (state == DONE) && (gnt == P_DMA);
  assign cpu_hold = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb with a behavioural SRAM and a reference memory for read data.
module tb_sram_arb;

  localparam int AC = 2;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vid_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0, dma_addr = '0;
  logic          cpu_we = 1'b0, dma_we = 1'b0;
  logic [7:0]    cpu_wdata = 8'h00, dma_wdata = 8'h00;
  logic          vid_ack, cpu_ack, dma_ack;
  logic [7:0]    rdata;
  logic          cpu_hold;
  logic [AW-1:0] ext_ad;
  logic [7:0]    ext_dq_o;
  logic          ext_dq_oe;
  logic [7:0]    ext_dq_i = 8'h00;
  logic          ext_cs, ext_oe_n, ext_we_n;

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;
  int multi    = 0;

  logic [7:0] sram    [int];
  logic [7:0] ref_mem [int];

  sram_arb #(.ACCESS_CYCLES(AC), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .cpu_req(cpu_req), .dma_req(dma_req),
    .vid_addr(vid_addr), .cpu_addr(cpu_addr), .dma_addr(dma_addr),
    .cpu_we(cpu_we), .dma_we(dma_we),
    .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .vid_ack(vid_ack), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
    .rdata(rdata), .cpu_hold(cpu_hold),
    .ext_ad(ext_ad), .ext_dq_o(ext_dq_o), .ext_dq_oe(ext_dq_oe),
    .ext_dq_i(ext_dq_i), .ext_cs(ext_cs), .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return {4'hA, a[3:0]};
  endfunction

  function automatic logic [7:0] exp_mem(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // SRAM: writes land on the strobe edge, read data settles half a cycle after the address.
  always @(posedge clk)
    if (ext_cs && !ext_we_n) sram[int'(ext_ad)] = ext_dq_o;

  always @(negedge clk)
    ext_dq_i = sram.exists(int'(ext_ad)) ? sram[int'(ext_ad)] : dflt(ext_ad);

  always @(negedge clk) begin
    if (!ext_oe_n && !ext_we_n) overlap++;
    if ((int'(vid_ack) + int'(cpu_ack) + int'(dma_ack)) > 1) multi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? vid_ack : (p == 1) ? cpu_ack : dma_ack;
  endfunction

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [7:0] wd);
    case (p)
      0: begin vid_req = req; vid_addr = addr; end
      1: begin cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
      default: begin dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd; end
    endcase
  endtask

  // One transfer from an idle arbiter; grantee inputs are scrambled after the grant.
  task automatic do_xfer(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [7:0] wd, input bit drop_early);
    int cyc = 0, oe_lo = 0, we_lo = 0, dqoe = 0, dq_bad = 0, stray = 0;
    logic got = 1'b0, hold1 = 1'b0;
    @(negedge clk);
    drive(p, 1'b1, we, addr, wd);
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        hold1 = cpu_hold;
        drive(p, !drop_early, !we, ~addr, ~wd);
      end
      if (!ext_oe_n) oe_lo++;
      if (!ext_we_n) we_lo++;
      if (ext_dq_oe) begin
        dqoe++;
        if (ext_dq_o !== wd) dq_bad++;
      end
      for (int q = 0; q < 3; q++)
        if (q != p && ack_of(q)) stray++;
      if (ack_of(p)) got = 1'b1;
    end
    check("ack_seen", got, 1);
    check("ack_latency", cyc, AC + 1);
    check("oe_low_cycles", oe_lo, we ? 0 : AC);
    check("we_low_cycles", we_lo, we ? AC : 0);
    check("dq_oe_cycles", dqoe, we ? AC + 1 : 0);
    check("dq_o_data", dq_bad, 0);
    check("stray_ack", stray, 0);
    check("ad_held_done", ext_ad, addr);
    check("cs_done", ext_cs, 1);
    if (p == 1) begin
      check("cpu_hold_access", hold1, 1);
      check("cpu_hold_ack", cpu_hold, 0);
    end
    if (we) ref_mem[int'(addr)] = wd;
    else    check("rdata", rdata, exp_mem(addr));
    drive(p, 1'b0, we, addr, wd);
    @(negedge clk);
    check("ack_one_cycle", ack_of(p), 0);
    check("idle_cs", ext_cs, 0);
    check("idle_ad_hold", ext_ad, addr);
  endtask

  // CPU and DMA held together for ntx transfers; grants must alternate.
  task automatic pair(input int ntx, input int first);
    int n = 0, last = 0, gap_bad = 0, first_cyc = 0;
    int seq [8];
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 17'h00010, 8'h00);
    drive(2, 1'b1, 1'b0, 17'h00021, 8'h00);
    for (int c = 1; c <= 80 && n < ntx; c++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        seq[n] = cpu_ack ? 1 : 2;
        if (n == 0) first_cyc = c;
        else if (c - last != AC + 2) gap_bad++;
        last = c;
        n++;
        if (n == ntx) begin
          cpu_req = 1'b0;
          dma_req = 1'b0;
        end
      end
    end
    check("pair_count", n, ntx);
    check("pair_first_latency", first_cyc, AC + 1);
    check("pair_gap", gap_bad, 0);
    for (int i = 0; i < n; i++)
      check($sformatf("pair_grant%0d", i), seq[i], ((i % 2) == 0) ? first : 3 - first);
    @(negedge clk);
  endtask

  initial begin
    int order [3];
    int at    [3];
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", ext_cs, 0);
    check("rst_oe_n", ext_oe_n, 1);
    check("rst_we_n", ext_we_n, 1);
    check("rst_dq_oe", ext_dq_oe, 0);
    check("rst_ad", ext_ad, 0);
    check("rst_rdata", rdata, 0);
    check("rst_acks", {vid_ack, cpu_ack, dma_ack}, 0);
    rst_n = 1'b1;

    // CPU read returns the model's 0xA5 at 0x1C005
    do_xfer(1, 1'b0, 17'h1C005, 8'h00, 1'b0);
    check("cpu_read_a5", rdata, 8'hA5);

    // DMA write 0x3C to 0x00100, then read it back through the CPU
    do_xfer(2, 1'b1, 17'h00100, 8'h3C, 1'b0);
    check("sram_0x100", sram.exists(32'h100) ? sram[32'h100] : 8'h00, 8'h3C);
    do_xfer(1, 1'b0, 17'h00100, 8'h00, 1'b0);

    // Request withdrawn right after grant still completes
    do_xfer(0, 1'b0, 17'h00007, 8'h00, 1'b1);
    do_xfer(2, 1'b1, 17'h00102, 8'h5E, 1'b1);

    // All three requests in one cycle: video, CPU, DMA
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 17'h00031, 8'h00);
    drive(1, 1'b1, 1'b0, 17'h00032, 8'h00);
    drive(2, 1'b1, 1'b0, 17'h00033, 8'h00);
    n = 0;
    for (int c = 1; c <= 40 && n < 3; c++) begin
      @(negedge clk);
      for (int q = 0; q < 3; q++)
        if (ack_of(q) && n < 3) begin
          order[n] = q;
          at[n] = c;
          n++;
          drive(q, 1'b0, 1'b0, 17'h0, 8'h00);
        end
    end
    check("tri_count", n, 3);
    check("tri_first", order[0], 0);
    check("tri_second", order[1], 1);
    check("tri_third", order[2], 2);
    check("tri_first_lat", at[0], AC + 1);
    check("tri_gap1", at[1] - at[0], AC + 2);
    check("tri_gap2", at[2] - at[1], AC + 2);
    @(negedge clk);

    // Last grant was DMA, so the held pair starts with CPU
    pair(6, 1);

    // Reset in the middle of a CPU write
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 17'h00200, 8'h77);
    @(negedge clk);
    check("pre_rst_we_n", ext_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we_n", ext_we_n, 1);
    check("rst_mid_dq_oe", ext_dq_oe, 0);
    check("rst_mid_cs", ext_cs, 0);
    check("rst_mid_ad", ext_ad, 0);
    cpu_req = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack || vid_ack || dma_ack) n++;
    end
    check("rst_no_ack", n, 0);
    rst_n = 1'b1;
    pair(2, 1);
    do_xfer(2, 1'b1, 17'h00103, 8'hC4, 1'b0);

    // Random traffic against the reference memory
    for (int i = 0; i < 16; i++) begin
      int p;
      logic w;
      p = int'($urandom_range(0, 2));
      w = (p != 0) && ($urandom_range(0, 1) == 1);
      do_xfer(p, w, 17'h00100 + 17'($urandom_range(0, 3)), 8'($urandom), 1'b0);
    end

    check("strobe_overlap", overlap, 0);
    check("multi_ack", multi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
